updown_counter_param: RTL and testbench
=======================================

// Module: updown_counter_param
//
// PURPOSE
//   Parametrised up/down counter: next generation of the lab 3-bit en/dir counter.
//   Adds configurable width and modulus, wrap or saturate mode, parallel load,
//   synchronous clear, an enable prescaler, a terminal-count flag and a limit-event pulse.
//   Used as a timebase/event counter feeding later lab blocks (display, FSM timers).
//
// PARAMETERS
//   WIDTH     8             counter width in bits (2..32)
//   MAX_VAL   2**WIDTH-1    top of count range; count stays in 0..MAX_VAL (MAX_VAL >= 1)
//   PRESCALE  1             enabled clk cycles per count step (1 = step every enabled cycle)
//   SATURATE  0             0 = wrap at limits, 1 = hold at limits
//
// PORTS
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   en        in   1      count enable; 0 freezes count and prescaler
//   dir       in   1      1 = up, 0 = down
//   clr       in   1      synchronous clear to 0
//   load      in   1      synchronous parallel load
//   load_val  in   WIDTH  value for load
//   count     out  WIDTH  current count (registered)
//   tc        out  1      terminal count: (dir & count==MAX_VAL) | (~dir & count==0); combinational
//   evt       out  1      registered 1-cycle pulse: a step hit a limit (wrapped or saturated)
//
// BEHAVIOUR
//   - Reset (rst_n=0, async): count=0, evt=0, prescaler psc=0; takes effect immediately,
//     mid-step included. Release is synchronous to the next clk edge.
//   - Per-edge priority: clr > load > step. clr and load act regardless of en.
//   - clr: count<=0, psc<=0, evt<=0.
//   - load: count <= (load_val > MAX_VAL) ? MAX_VAL : load_val; psc<=0; evt<=0.
//   - Prescaler: with en=1, psc increments each edge. When psc==PRESCALE-1, psc<=0 and
//     a step occurs on that edge. PRESCALE=1: step every enabled edge.
//     en=0 holds psc and count. dir changes do not reset psc.
//   - Step up (dir=1): count<MAX_VAL -> count+1; count==MAX_VAL -> 0 (wrap) or hold (SATURATE).
//   - Step down (dir=0): count>0 -> count-1; count==0 -> MAX_VAL (wrap) or hold (SATURATE).
//   - evt <= 1 on the edge of a step taken from the limit (tc was 1), in either mode;
//     otherwise evt <= 0. Latency: evt is high in the same cycle count shows the new value.
//   - Arithmetic is WIDTH bits, compared against MAX_VAL; count never exceeds MAX_VAL.
//     Non-power-of-2 MAX_VAL wraps at MAX_VAL, not at 2**WIDTH-1.
//   - tc is combinational from count and dir; it tracks a dir change in the same cycle.
//   - Latency: count updates one edge after the qualifying input; no pipeline stages.
//
// TESTING
//   1. Reset: rst_n=0 asserted mid-count (count=5) -> count=0, evt=0 immediately, no clk edge.
//   2. WIDTH=3, wrap, en=1, dir=1, 10 edges from 0 -> 1..7,0,1,2; evt high only with count=0.
//   3. WIDTH=4, MAX_VAL=9, down from load 2, 4 steps -> 1,0,9,8; tc=1 at 0; evt with 9.
//   4. SATURATE=1, MAX_VAL=9, up from 8, 3 steps -> 9,9,9; evt on 2nd and 3rd step; tc=1.
//   5. PRESCALE=4, en=1 for 12 edges with en=0 for 3 edges after edge 6 -> count +1 at
//      enabled edges 4, 8, 12 only; frozen while en=0.
//   6. Priority: clr=1, load=1, load_val=5, en=1 on the same edge -> count=0. Then load_val=12
//      with MAX_VAL=9, load=1 -> count=9, psc=0.

Source files
------------

// File: rtl/updown_counter_param.sv
// ----------------------------------------------------------------------------
// updown_counter_param
//   Parametrised up/down counter used as a timebase/event counter.
//   Configurable width and modulus, wrap or saturate at the limits,
//   parallel load, synchronous clear, enable prescaler, terminal-count
//   flag and a one-cycle limit-event pulse.
//
// Parameters
//   WIDTH     counter width in bits (2..32)
//   MAX_VAL   top of the count range; count stays in 0..MAX_VAL
//   PRESCALE  enabled clock cycles per count step (1 = every enabled cycle)
//   SATURATE  0 = wrap at the limits, 1 = hold at the limits
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   en        count enable; 0 freezes count and prescaler
//   dir       1 = count up, 0 = count down
//   clr       synchronous clear to 0 (highest priority, ignores en)
//   load      synchronous parallel load (ignores en)
//   load_val  value to load, clipped to MAX_VAL
//   count     current count (registered)
//   tc        terminal count for the current direction (combinational)
//   evt       registered pulse: the last step was taken from a limit
// ----------------------------------------------------------------------------
module updown_counter_param #(
  parameter int                WIDTH    = 8,
  parameter logic [WIDTH-1:0]  MAX_VAL  = {WIDTH{1'b1}},
  parameter int                PRESCALE = 1,
  parameter int                SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             evt
);

  localparam int               PSC_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_TOP = PSC_W'(PRESCALE - 1);

  logic [PSC_W-1:0] psc;

  // Next count for one step; the limit behaviour (wrap or hold) lives here.
  function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] cur,
                                                input logic             up);
    logic [WIDTH-1:0] nxt;
    if (up) begin
      if (cur == MAX_VAL)
        nxt = (SATURATE != 0) ? cur : '0;
      else
        nxt = cur + WIDTH'(1);
    end else begin
      if (cur == '0)
        nxt = (SATURATE != 0) ? cur : MAX_VAL;
      else
        nxt = cur - WIDTH'(1);
    end
    return nxt;
  endfunction

  // Loaded values above the modulus are clamped so count never leaves range.
  function automatic logic [WIDTH-1:0] clip_load(input logic [WIDTH-1:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  assign tc = dir ? (count == MAX_VAL) : (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      psc   <= '0;
      evt   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      psc   <= '0;
      evt   <= 1'b0;
    end else if (load) begin
      count <= clip_load(load_val);
      psc   <= '0;
      evt   <= 1'b0;
    end else if (en) begin
      if (psc == PSC_TOP) begin
        // tc is the "currently at the limit" flag, so a step taken with tc
        // high is exactly a step that wraps or saturates.
        psc   <= '0;
        count <= step_val(count, dir);
        evt   <= tc;
      end else begin
        psc   <= psc + PSC_W'(1);
        evt   <= 1'b0;
      end
    end else begin
      evt <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// ----------------------------------------------------------------------------
// tb_updown_counter_param
//   Scoreboard bench for updown_counter_param. Four instances cover the
//   configurations of interest:
//     d0: WIDTH=3, wrap
//     d1: WIDTH=4, MAX_VAL=9, wrap
//     d2: WIDTH=4, MAX_VAL=9, saturate
//     d3: WIDTH=4, PRESCALE=4, wrap
//   Stimulus pushes hand-computed expectations into a queue; a separate
//   monitor process pops and compares them whenever a sample is announced.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_updown_counter_param;

  logic       clk;
  logic       rst_n;
  logic [3:0] en, dir, clr, load;
  logic [3:0] lv [4];

  logic [2:0] c0;
  logic [3:0] c1, c2, c3;
  logic [3:0] t, e;

  typedef struct {
    int         d;
    logic [3:0] c;
    logic       ev;
    logic       tcv;
    string      nm;
  } exp_t;

  exp_t sbq[$];
  int   total;
  int   bad;
  event chk;

  updown_counter_param #(.WIDTH(3)) d0 (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .dir(dir[0]), .clr(clr[0]),
    .load(load[0]), .load_val(lv[0][2:0]), .count(c0), .tc(t[0]), .evt(e[0])
  );

  updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd9)) d1 (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .dir(dir[1]), .clr(clr[1]),
    .load(load[1]), .load_val(lv[1]), .count(c1), .tc(t[1]), .evt(e[1])
  );

  updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1)) d2 (
    .clk(clk), .rst_n(rst_n), .en(en[2]), .dir(dir[2]), .clr(clr[2]),
    .load(load[2]), .load_val(lv[2]), .count(c2), .tc(t[2]), .evt(e[2])
  );

  updown_counter_param #(.WIDTH(4), .PRESCALE(4)) d3 (
    .clk(clk), .rst_n(rst_n), .en(en[3]), .dir(dir[3]), .clr(clr[3]),
    .load(load[3]), .load_val(lv[3]), .count(c3), .tc(t[3]), .evt(e[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // Monitor: pop every pending expectation and compare against the DUT.
  initial begin
    forever begin
      @(chk);
      while (sbq.size() > 0) begin
        exp_t       x;
        logic [3:0] ac;
        logic       aev, atc;
        x = sbq.pop_front();
        case (x.d)
          0:       begin ac = {1'b0, c0}; aev = e[0]; atc = t[0]; end
          1:       begin ac = c1;         aev = e[1]; atc = t[1]; end
          2:       begin ac = c2;         aev = e[2]; atc = t[2]; end
          default: begin ac = c3;         aev = e[3]; atc = t[3]; end
        endcase
        total++;
        if (ac !== x.c) begin
          bad++;
          $display("FAIL %s.count d%0d got=%0d want=%0d", x.nm, x.d, ac, x.c);
        end
        total++;
        if (aev !== x.ev) begin
          bad++;
          $display("FAIL %s.evt d%0d got=%b want=%b", x.nm, x.d, aev, x.ev);
        end
        total++;
        if (atc !== x.tcv) begin
          bad++;
          $display("FAIL %s.tc d%0d got=%b want=%b", x.nm, x.d, atc, x.tcv);
        end
      end
    end
  end

  task automatic exp_push(input int d, input int c, input bit ev, input bit tcv,
                          input string nm);
    exp_t x;
    x.d   = d;
    x.c   = 4'(c);
    x.ev  = ev;
    x.tcv = tcv;
    x.nm  = nm;
    sbq.push_back(x);
  endtask

  // One clock edge, then announce a sample 2 ns later; inputs change at +3.
  task automatic tick();
    @(posedge clk);
    #2;
    ->chk;
    #1;
  endtask

  // Announce a sample without waiting for any clock edge.
  task automatic check_now();
    ->chk;
    #1;
  endtask

  int ex3 [4]  = '{1, 0, 9, 8};
  int en5 [15] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
  int ex5 [15] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 3};
  int ex5b[4]  = '{7, 7, 7, 8};

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    en = '0; dir = '0; clr = '0; load = '0;
    for (int i = 0; i < 4; i++) lv[i] = '0;

    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Reset state: count 0, evt 0, dir=0 so tc reports the lower limit.
    for (int i = 0; i < 4; i++) exp_push(i, 0, 0, 1, "reset_state");
    check_now();

    // Count d0 to 5, then pull reset mid-cycle with no clock edge.
    en[0] = 1'b1; dir[0] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      exp_push(0, i, 0, 0, "pre_reset");
      tick();
    end
    exp_push(0, 0, 0, 0, "async_reset");
    rst_n = 1'b0;
    #1;
    check_now();
    rst_n = 1'b1;

    // WIDTH=3 wrap: 1..7,0,1,2; evt only with 0, tc only at 7.
    for (int i = 1; i <= 10; i++) begin
      exp_push(0, i % 8, (i % 8) == 0, (i % 8) == 7, "wrap_w3");
      tick();
    end
    en[0] = 1'b0;

    // MAX_VAL=9 down from a load of 2: 1,0,9,8.
    lv[1] = 4'd2; load[1] = 1'b1;
    exp_push(1, 2, 0, 0, "load_m9");
    tick();
    load[1] = 1'b0; en[1] = 1'b1; dir[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_push(1, ex3[i], ex3[i] == 9, ex3[i] == 0, "down_m9");
      tick();
    end
    en[1] = 1'b0;

    // Saturating up from 8: 9,9,9 with evt on the 2nd and 3rd step.
    lv[2] = 4'd8; load[2] = 1'b1; dir[2] = 1'b1;
    exp_push(2, 8, 0, 0, "sat_load");
    tick();
    load[2] = 1'b0; en[2] = 1'b1;
    exp_push(2, 9, 0, 1, "sat_up1");
    tick();
    exp_push(2, 9, 1, 1, "sat_up2");
    tick();
    exp_push(2, 9, 1, 1, "sat_up3");
    tick();
    en[2] = 1'b0;
    exp_push(2, 9, 0, 1, "sat_evt_drop");
    tick();
    // Saturating down at zero holds and still pulses evt.
    lv[2] = 4'd0; load[2] = 1'b1; dir[2] = 1'b0;
    exp_push(2, 0, 0, 1, "sat_load0");
    tick();
    load[2] = 1'b0; en[2] = 1'b1;
    exp_push(2, 0, 1, 1, "sat_down");
    tick();
    en[2] = 1'b0;

    // PRESCALE=4 with a 3-cycle enable gap after the 6th enabled edge.
    dir[3] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      en[3] = en5[i][0];
      exp_push(3, ex5[i], 0, 0, "prescale");
      tick();
    end
    // Two more enabled edges leave the prescaler mid-period.
    exp_push(3, 3, 0, 0, "psc_mid");
    tick();
    exp_push(3, 3, 0, 0, "psc_mid");
    tick();
    // A load must restart the prescaler: next step after 4 enabled edges.
    lv[3] = 4'd7; load[3] = 1'b1;
    exp_push(3, 7, 0, 0, "psc_load");
    tick();
    load[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_push(3, ex5b[i], 0, 0, "psc_after_load");
      tick();
    end
    en[3] = 1'b0;

    // Priority: clr beats load and step.
    clr[1] = 1'b1; load[1] = 1'b1; lv[1] = 4'd5; en[1] = 1'b1; dir[1] = 1'b1;
    exp_push(1, 0, 0, 0, "clr_prio");
    tick();
    // Load above MAX_VAL clamps to 9; load beats the step.
    clr[1] = 1'b0; lv[1] = 4'd12;
    exp_push(1, 9, 0, 1, "load_clip");
    tick();
    // Step up from 9 wraps at the modulus, not at 15.
    load[1] = 1'b0;
    exp_push(1, 0, 1, 0, "wrap_m9");
    tick();
    en[1] = 1'b0;

    #20;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
